// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit word-addressed CPU: data/address widths,
// opcode encodings and the instruction-queue entry used by the fetch stage.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_BNE  = 4'hB;
  localparam logic [3:0] OP_LUI  = 4'hC;
  localparam logic [3:0] OP_JAL  = 4'hD;
  localparam logic [3:0] OP_JR   = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fq_entry_t;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1:INSTR_W-4];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {instr, pc} entries. The head entry is
// presented combinationally; clear empties the queue and wins over push/pop.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  fq_entry_t                 push_data,
  input  logic                      pop,
  input  logic                      clear,
  output logic [$clog2(QDEPTH):0]   count,
  output fq_entry_t                 head
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  fq_entry_t         mem [QDEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop & !clear & (count != '0);
  assign do_push = push & !clear & ((count < CW'(QDEPTH)) | do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from instruction memory
// over a zero-latency req/rdy handshake, queues them and hands the head to decode.
// Build option FETCH_HALT_EN: a fetched opcode-F word halts fetch until reset.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                QDEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rdy,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_plus1,
  output logic               instr_vld,
  output logic               hlt
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [ADDR_W-1:0] pc;
  logic              req_en;
  logic [CW-1:0]     count;
  fq_entry_t         head;
  fq_entry_t         push_data;
  logic              flush_eff;
  logic              pop;
  logic              xfer;
  logic              push;

`ifdef FETCH_HALT_EN
  logic hlt_q;
  logic is_halt;

  assign is_halt   = (opcode_of(imem_rdata) == OP_HLT);
  assign push      = xfer & !is_halt;
  assign flush_eff = flush & !hlt_q;
  assign hlt       = hlt_q;

  // Halt is sticky: once a halt word has been fetched only reset restarts fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 hlt_q <= 1'b0;
    else if (xfer & is_halt) hlt_q <= 1'b1;
  end
`else
  assign push      = xfer;
  assign flush_eff = flush;
  assign hlt       = 1'b0;
`endif

  assign instr_vld = (count != '0);
  assign pop       = instr_vld & !stall & !flush_eff;
  // req_en keeps the request low for the first cycle out of reset.
  assign imem_req  = req_en & !flush_eff & !hlt & ((count < CW'(QDEPTH)) | pop);
  assign imem_addr = pc;
  assign xfer      = imem_req & imem_rdy;

  assign push_data.instr = imem_rdata;
  assign push_data.pc    = pc;

  assign instr    = instr_vld ? head.instr : '0;
  assign instr_pc = instr_vld ? head.pc    : '0;
  assign pc_plus1 = instr_vld ? head.pc + 16'd1 : '0;

  // Fetch PC: redirect has priority, otherwise advance on every accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_en <= 1'b0;
    end else begin
      req_en <= 1'b1;
      if (flush_eff) pc <= redirect_pc;
      else if (xfer) pc <= pc + 16'd1;
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (flush_eff),
    .count     (count),
    .head      (head)
  );

endmodule
